// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding and digit limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPaused = 2'b10,
        StLap    = 2'b11
    } sw_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // The live count advances in both RUN and LAP; LAP only freezes the display.
    function automatic logic is_counting(sw_state_e s);
        return (s == StRun) || (s == StLap);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Button press detector: a press is a 0->1 change relative to the previous sample.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic prev_q;

    // Remember last sampled level so a held button yields exactly one press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign press_o = btn_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// BCD stopwatch controller: start/stop, lap hold, clear, prescaled tick and
// a cascaded decimal counter with a sticky overflow flag.
module stopwatch_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_stop,
    input  logic                    lap,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] disp,
    output logic                    running,
    output logic                    lap_hold,
    output logic                    overflow,
    output logic                    tick
);

    import stopwatch_pkg::*;

    localparam int unsigned CntW   = 4 * NUM_DIGITS;
    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescTop = PrescW'(TICK_DIV - 1);

    sw_state_e          state_q;
    logic               running_q;
    logic               lap_hold_q;
    logic               overflow_q;
    logic [CntW-1:0]    lap_q;
    logic [CntW-1:0]    count;
    logic [PrescW-1:0]  presc_q;
    logic [NUM_DIGITS:0] carry;

    logic ss_press, lap_press, clr_press;
    logic ss_evt, lap_evt, clr_evt;
    logic counting, do_clear;

    rise_detect u_rd_start_stop (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (start_stop),
        .press_o (ss_press)
    );

    rise_detect u_rd_lap (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (lap),
        .press_o (lap_press)
    );

    rise_detect u_rd_clear (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (clear),
        .press_o (clr_press)
    );

    // Only the highest-priority press in a cycle survives.
    always_comb begin
        ss_evt  = ss_press;
        lap_evt = lap_press & ~ss_press;
        clr_evt = clr_press & ~ss_press & ~lap_press;
    end

    // Eligibility uses the pre-transition state, so a tick on a stop press still counts.
    assign counting = is_counting(state_q);
    assign tick     = counting & (presc_q == PrescTop);
    assign do_clear = (state_q == StPaused) & clr_evt;

    // Prescaler: free-runs while counting, freezes when paused, zero when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (counting) begin
            presc_q <= tick ? '0 : presc_q + PrescW'(1);
        end else if ((state_q == StIdle) || do_clear) begin
            presc_q <= '0;
        end
    end

    // Ripple carry: digit i increments when every lower digit is rolling over.
    always_comb begin
        carry    = '0;
        carry[0] = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            carry[i+1] = carry[i] & (count[4*i +: 4] == BCD_MAX);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] digit_q;

        // Each digit wraps 9->0; the wrap feeds the next digit in the same cycle.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                digit_q <= '0;
            end else if (do_clear) begin
                digit_q <= '0;
            end else if (carry[i]) begin
                digit_q <= (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end
        end

        assign count[4*i +: 4] = digit_q;
    end

    // Overflow is sticky until a clear or reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (do_clear) begin
            overflow_q <= 1'b0;
        end else if (carry[NUM_DIGITS]) begin
            overflow_q <= 1'b1;
        end
    end

    // Control FSM with registered status outputs and the lap latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            lap_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_evt) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (ss_evt) begin
                        state_q   <= StPaused;
                        running_q <= 1'b0;
                    end else if (lap_evt) begin
                        state_q    <= StLap;
                        lap_hold_q <= 1'b1;
                        lap_q      <= count;
                    end
                end
                StLap: begin
                    if (ss_evt) begin
                        state_q    <= StPaused;
                        running_q  <= 1'b0;
                        lap_hold_q <= 1'b0;
                    end else if (lap_evt) begin
                        state_q    <= StRun;
                        lap_hold_q <= 1'b0;
                    end
                end
                StPaused: begin
                    if (ss_evt) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end else if (clr_evt) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    running_q  <= 1'b0;
                    lap_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign overflow = overflow_q;
    assign disp     = lap_hold_q ? lap_q : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: integer-count reference model, expected
// outputs queued per cycle by the driver and compared by an independent monitor.
module tb_stopwatch_ctrl;

    localparam int ND     = 4;
    localparam int TD     = 4;
    localparam int MAXC   = 9999;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_LAP = 3;

    logic          clock = 1'b0;
    logic          reset, start_stop, lap, clear;
    logic [4*ND-1:0] disp;
    logic          running, lap_hold, overflow, tick;

    stopwatch_ctrl #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp       (disp),
        .running    (running),
        .lap_hold   (lap_hold),
        .overflow   (overflow),
        .tick       (tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4*ND-1:0] disp;
        logic            run;
        logic            lh;
        logic            ovf;
        logic            tck;
        bit              chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   sparse   = 1'b0;

    // Reference model: plain integer count, state names and previous button levels.
    int m_state, m_count, m_lap, m_presc;
    bit m_ovf, m_pss, m_plp, m_pcl;

    function automatic void model_reset();
        m_state = M_IDLE; m_count = 0; m_lap = 0; m_presc = 0;
        m_ovf = 1'b0; m_pss = 1'b0; m_plp = 1'b0; m_pcl = 1'b0;
    endfunction

    function automatic logic [4*ND-1:0] to_bcd(int v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model_step(bit ss, bit lp, bit cl);
        bit e_ss, e_lp, e_cl, cnt, t;
        int old;
        e_ss = ss && !m_pss;
        e_lp = lp && !m_plp && !e_ss;
        e_cl = cl && !m_pcl && !e_ss && !(lp && !m_plp);
        m_pss = ss; m_plp = lp; m_pcl = cl;
        cnt = (m_state == M_RUN) || (m_state == M_LAP);
        t   = cnt && (m_presc == TD - 1);
        old = m_count;
        if (t) begin
            m_count = (m_count + 1) % (MAXC + 1);
            if (old == MAXC) m_ovf = 1'b1;
        end
        if (cnt) m_presc = t ? 0 : m_presc + 1;
        else if (m_state == M_IDLE) m_presc = 0;
        case (m_state)
            M_IDLE: if (e_ss) m_state = M_RUN;
            M_RUN: begin
                if (e_ss) m_state = M_PAUSED;
                else if (e_lp) begin m_state = M_LAP; m_lap = old; end
            end
            M_LAP: begin
                if (e_ss) m_state = M_PAUSED;
                else if (e_lp) m_state = M_RUN;
            end
            default: begin
                if (e_ss) m_state = M_RUN;
                else if (e_cl) begin
                    m_state = M_IDLE; m_count = 0; m_ovf = 1'b0; m_presc = 0;
                end
            end
        endcase
    endfunction

    function automatic exp_t model_out(bit chk);
        exp_t e;
        e.disp = to_bcd((m_state == M_LAP) ? m_lap : m_count);
        e.run  = (m_state == M_RUN) || (m_state == M_LAP);
        e.lh   = (m_state == M_LAP);
        e.ovf  = m_ovf;
        e.tck  = e.run && (m_presc == TD - 1);
        e.chk  = chk;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_disp"}, 32'(disp), 32'h0);
        check({name, "_running"}, 32'(running), 32'h0);
        check({name, "_lap_hold"}, 32'(lap_hold), 32'h0);
        check({name, "_overflow"}, 32'(overflow), 32'h0);
        check({name, "_tick"}, 32'(tick), 32'h0);
    endtask

    // Drive one cycle of button levels; queue the outputs expected after the edge.
    task automatic step(input bit ss, input bit lp, input bit cl);
        bit chk;
        start_stop = ss; lap = lp; clear = cl;
        model_step(ss, lp, cl);
        chk = !sparse || (m_count % 100 >= 98) || (m_count % 100 == 0);
        @(posedge clock);
        exp_q.push_back(model_out(chk));
        #1;
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (m_count != target && n < 60000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_count != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_until: count %0d, wanted %0d", m_count, target);
        end
    endtask

    // Reset pulse entirely between two clock edges.
    task automatic async_reset();
        @(negedge clock);
        #1;
        reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if ({disp, running, lap_hold, overflow, tick} !==
                        {e.disp, e.run, e.lh, e.ovf, e.tck}) begin
                        n_errors++;
                        $display("FAIL outputs @%0t: got disp=%h run=%b lap_hold=%b ovf=%b tick=%b, expected disp=%h run=%b lap_hold=%b ovf=%b tick=%b",
                                 $time, disp, running, lap_hold, overflow, tick,
                                 e.disp, e.run, e.lh, e.ovf, e.tck);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit rs, rl, rc;
        reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Start and count 40 cycles: ten ticks.
        step(1'b1, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b0, 1'b0);
        check("run40_disp", 32'(disp), 32'h0010);
        check("run40_running", 32'(running), 32'h1);

        // Lap hold freezes the display while the count moves on.
        run_until(12);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_until(15);
        check("lap_frozen_disp", 32'(disp), 32'h0012);
        check("lap_hold_on", 32'(lap_hold), 32'h1);
        step(1'b0, 1'b1, 1'b0);
        check("lap_release_disp", 32'(disp), 32'h0015);
        check("lap_release_hold", 32'(lap_hold), 32'h0);

        // start_stop beats lap; a held start_stop is one press.
        step(1'b1, 1'b1, 1'b0);
        check("both_press_running", 32'(running), 32'h0);
        check("both_press_lap_hold", 32'(lap_hold), 32'h0);
        check("both_press_disp", 32'(disp), 32'h0015);
        step(1'b0, 1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b0, 1'b0);
        check("held_ss_running", 32'(running), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Pause, clear, restart, stop at 7, clear again, clear while running.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("clear_idle_disp", 32'(disp), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_until(7);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("paused_disp", 32'(disp), 32'h0007);
        check("paused_running", 32'(running), 32'h0);
        step(1'b0, 1'b0, 1'b1);
        check("clear_disp", 32'(disp), 32'h0);
        check("clear_overflow", 32'(overflow), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_until(3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("clear_in_run_disp", 32'(disp), 32'h0003);
        check("clear_in_run_running", 32'(running), 32'h1);

        // Carry across digits and wrap from all nines.
        run_until(99);
        run_until(100);
        check("carry_disp", 32'(disp), 32'h0100);
        sparse = 1'b1;
        run_until(MAXC);
        check("all_nines_disp", 32'(disp), 32'h9999);
        run_until(0);
        sparse = 1'b0;
        check("wrap_disp", 32'(disp), 32'h0000);
        check("wrap_overflow", 32'(overflow), 32'h1);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run, then resume from IDLE.
        async_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        check("resume_disp", 32'(disp), 32'h0002);
        check("resume_overflow", 32'(overflow), 32'h0);

        // Random button activity against the model.
        rs = 1'b0; rl = 1'b0; rc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 11) == 0) rs = !rs;
            if ($urandom_range(0, 5) == 0) rl = !rl;
            if ($urandom_range(0, 4) == 0) rc = !rc;
            step(rs, rl, rc);
            if (i == 1000) begin
                async_reset();
                rs = 1'b0; rl = 1'b0; rc = 1'b0;
            end
        end

        step(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
